// File: rtl/mem_arb_pkg.sv
// Memory arbiter shared types and constants.
// States, legal transfer sizes and a size check helper.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    ISSUE   = 3'b010,
    RELEASE = 3'b100
  } state_t;

  localparam logic [2:0] NB_1 = 3'd1;
  localparam logic [2:0] NB_2 = 3'd2;
  localparam logic [2:0] NB_4 = 3'd4;

  function automatic logic nb_legal(
    input logic [2:0] nb
  );
    return (nb == NB_1) || (nb == NB_2) ||
           (nb == NB_4);
  endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// Issue watchdog for the memory arbiter.
// Counts ISSUE cycles and flags the last allowed one.
module mem_arb_timeout #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TIMER_W        = 13
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TIMER_W-1:0] count;

  // cycle counter, restarted on every grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TIMER_W'(1);
    end
  end

  assign expired =
    (count == TIMER_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of mem_external.
// Grants one port, holds its command, returns done/err/rdata.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TIMER_W        = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_write,
  input  logic [2:0]  p0_num_bytes,
  input  logic [24:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_done,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_write,
  input  logic [2:0]  p1_num_bytes,
  input  logic [24:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_done,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic        mem_start_request,
  output logic        mem_is_write,
  output logic [2:0]  mem_num_bytes,
  output logic [24:0] mem_target_address,
  output logic [31:0] mem_write_value,
  input  logic [31:0] mem_fetched_value,
  input  logic        mem_request_done,
  output logic        grant,
  output logic        busy
);

  state_t state, state_next;
  logic last_grant;
  logic sel, owner;
  logic launch, reject, finish, fail;
  logic tmr_clear, tmr_en, expired;
  logic        sel_write;
  logic [2:0]  sel_nb;
  logic [24:0] sel_addr;
  logic [31:0] sel_wdata;

  assign busy = (state != IDLE);

  // choose the requester to serve from IDLE
  always_comb begin
    sel = 1'b0;
    if (p0_req && p1_req) begin
      sel = (ROUND_ROBIN != 0) ? ~last_grant : 1'b0;
    end else begin
      sel = p1_req;
    end
  end

  assign sel_write = sel ? p1_write     : p0_write;
  assign sel_nb    = sel ? p1_num_bytes : p0_num_bytes;
  assign sel_addr  = sel ? p1_addr      : p0_addr;
  assign sel_wdata = sel ? p1_wdata     : p0_wdata;

  // next state and per-cycle transfer control
  always_comb begin
    state_next = state;
    owner      = grant;
    launch     = 1'b0;
    reject     = 1'b0;
    finish     = 1'b0;
    fail       = 1'b0;
    tmr_clear  = 1'b0;
    tmr_en     = 1'b0;
    unique case (state)
      IDLE: begin
        owner = sel;
        if (p0_req || p1_req) begin
          if (nb_legal(sel_nb)) begin
            launch     = 1'b1;
            tmr_clear  = 1'b1;
            state_next = ISSUE;
          end else begin
            reject     = 1'b1;
            finish     = 1'b1;
            fail       = 1'b1;
            state_next = RELEASE;
          end
        end
      end
      ISSUE: begin
        if (mem_request_done) begin
          finish     = 1'b1;
          state_next = RELEASE;
        end else if (expired) begin
          finish     = 1'b1;
          fail       = 1'b1;
          state_next = RELEASE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      RELEASE: begin
        if (!mem_request_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // command latch, grant tracking and start level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant              <= 1'b0;
      last_grant         <= 1'b1;
      mem_start_request  <= 1'b0;
      mem_is_write       <= 1'b0;
      mem_num_bytes      <= '0;
      mem_target_address <= '0;
      mem_write_value    <= '0;
    end else begin
      if (launch || reject) begin
        grant <= sel;
      end
      if (launch) begin
        mem_start_request  <= 1'b1;
        mem_is_write       <= sel_write;
        mem_num_bytes      <= sel_nb;
        mem_target_address <= sel_addr;
        mem_write_value    <= sel_wdata;
      end
      if (state == ISSUE && finish) begin
        mem_start_request <= 1'b0;
        last_grant        <= grant;
      end
    end
  end

  // completion pulses and per-port load data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_done  <= 1'b0;
      p1_done  <= 1'b0;
      p0_err   <= 1'b0;
      p1_err   <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else begin
      p0_done <= finish & ~owner;
      p1_done <= finish & owner;
      p0_err  <= fail & ~owner;
      p1_err  <= fail & owner;
      if (state == ISSUE && mem_request_done &&
          !mem_is_write) begin
        if (grant) begin
          p1_rdata <= mem_fetched_value;
        end else begin
          p0_rdata <= mem_fetched_value;
        end
      end
    end
  end

  if (TIMEOUT_CYCLES != 0) begin : g_timeout
    mem_arb_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .TIMER_W       (TIMER_W)
    ) u_timeout (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (tmr_clear),
      .enable (tmr_en),
      .expired(expired)
    );
  end else begin : g_no_timeout
    logic unused_tmr;
    assign unused_tmr = tmr_clear ^ tmr_en;
    assign expired    = 1'b0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: round-robin/4096 and fixed/16 builds.
// Table vectors, directed corner sequences and random rounds.
module tb_mem_arbiter;

  typedef struct {
    bit          wr;
    logic [2:0]  nb;
    logic [24:0] addr;
    logic [31:0] wd;
  } cmd_t;

  typedef struct {
    int   d;
    int   m;
    cmd_t c0;
    cmd_t c1;
    int   lat;
    int   first;
    bit   e0;
    bit   e1;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req  [2][2];
  logic        wr   [2][2];
  logic [2:0]  nb   [2][2];
  logic [24:0] addr [2][2];
  logic [31:0] wd   [2][2];
  logic        done [2][2];
  logic        err  [2][2];
  logic [31:0] rd   [2][2];
  logic        start [2];
  logic        mwr   [2];
  logic [2:0]  mnb   [2];
  logic [24:0] maddr [2];
  logic [31:0] mwd   [2];
  logic        gnt   [2];
  logic        busy  [2];
  int          lat   [2];

  int errors = 0;
  int checks = 0;

  bit          last [2];
  logic [31:0] mrd  [2][2];
  logic [31:0] img  [logic [24:0]];

  function automatic logic [31:0] mem_read(
    input logic [24:0] a
  );
    if (img.exists(a)) return img[a];
    return {a[7:0] ^ 8'h3C, a[15:8],
            a[23:16] ^ 8'hA5, 7'h11, a[24]};
  endfunction

  function automatic bit legal(input logic [2:0] n);
    return n == 3'd1 || n == 3'd2 || n == 3'd4;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        mdone;
    logic [31:0] mfv;
    int          cnt;

    mem_arbiter #(
      .ROUND_ROBIN   (g == 0 ? 1 : 0),
      .TIMEOUT_CYCLES(g == 0 ? 4096 : 16),
      .TIMER_W       (13)
    ) u_dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .p0_req            (req[g][0]),
      .p0_write          (wr[g][0]),
      .p0_num_bytes      (nb[g][0]),
      .p0_addr           (addr[g][0]),
      .p0_wdata          (wd[g][0]),
      .p0_done           (done[g][0]),
      .p0_err            (err[g][0]),
      .p0_rdata          (rd[g][0]),
      .p1_req            (req[g][1]),
      .p1_write          (wr[g][1]),
      .p1_num_bytes      (nb[g][1]),
      .p1_addr           (addr[g][1]),
      .p1_wdata          (wd[g][1]),
      .p1_done           (done[g][1]),
      .p1_err            (err[g][1]),
      .p1_rdata          (rd[g][1]),
      .mem_start_request (start[g]),
      .mem_is_write      (mwr[g]),
      .mem_num_bytes     (mnb[g]),
      .mem_target_address(maddr[g]),
      .mem_write_value   (mwd[g]),
      .mem_fetched_value (mfv),
      .mem_request_done  (mdone),
      .grant             (gnt[g]),
      .busy              (busy[g])
    );

    // controller stand-in: done lat+1 cycles after start, held until start drops
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mdone <= 1'b0;
        cnt   <= 0;
        mfv   <= '0;
      end else if (!start[g]) begin
        mdone <= 1'b0;
        cnt   <= 0;
      end else if (!mdone) begin
        if (cnt == lat[g]) begin
          mdone <= 1'b1;
          mfv   <= mem_read(maddr[g]);
        end else begin
          cnt <= cnt + 1;
        end
      end
    end
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic cmd_t cm(bit w, logic [2:0] n,
                              logic [24:0] a,
                              logic [31:0] v);
    cmd_t c;
    c.wr = w; c.nb = n; c.addr = a; c.wd = v;
    return c;
  endfunction

  function automatic vec_t vt(int d, int m,
                              cmd_t c0, cmd_t c1,
                              int l, int f,
                              bit e0, bit e1);
    vec_t v;
    v.d = d; v.m = m; v.c0 = c0; v.c1 = c1;
    v.lat = l; v.first = f; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic set_cmd(input int d, input int p,
                         input cmd_t c);
    wr[d][p]   = c.wr;
    nb[d][p]   = c.nb;
    addr[d][p] = c.addr;
    wd[d][p]   = c.wd;
  endtask

  task automatic complete(input int d, input int p,
                          input cmd_t c, input bit e);
    int who;
    bit ok;
    who = -1;
    ok  = 1'b1;
    for (int i = 0; i < 300 && who < 0; i++) begin
      @(negedge clk);
      if (start[d] &&
          (gnt[d] !== p[0] || maddr[d] !== c.addr))
        ok = 1'b0;
      if (done[d][0] && done[d][1]) who = 2;
      else if (done[d][0]) who = 0;
      else if (done[d][1]) who = 1;
    end
    check($sformatf("done_port d%0d", d), who, p);
    check($sformatf("cmd_hold d%0d", d), 32'(ok), 1);
    check($sformatf("err d%0d p%0d", d, p),
          32'(err[d][p]), 32'(e));
    if (!e && !c.wr) mrd[d][p] = mem_read(c.addr);
    check($sformatf("rdata d%0d p%0d", d, p),
          rd[d][p], mrd[d][p]);
    if (legal(c.nb)) last[d] = p[0];
    if (who != 1) req[d][0] = 1'b0;
    if (who != 0) req[d][1] = 1'b0;
  endtask

  task automatic tail(input int d);
    @(negedge clk);
    check($sformatf("one_pulse d%0d", d),
          {30'd0, done[d][0], done[d][1]}, 0);
    for (int i = 0; i < 10 && busy[d]; i++)
      @(negedge clk);
    check($sformatf("idle d%0d", d), 32'(busy[d]), 0);
  endtask

  task automatic run_round(input vec_t v);
    lat[v.d] = v.lat;
    set_cmd(v.d, 0, v.c0);
    set_cmd(v.d, 1, v.c1);
    req[v.d][0] = v.m[0];
    req[v.d][1] = v.m[1];
    complete(v.d, v.first,
             v.first ? v.c1 : v.c0,
             v.first ? v.e1 : v.e0);
    if (v.m == 3)
      complete(v.d, 1 - v.first,
               v.first ? v.c0 : v.c1,
               v.first ? v.e0 : v.e1);
    tail(v.d);
  endtask

  function automatic cmd_t rnd_cmd();
    logic [2:0] sizes [8];
    sizes = '{3'd1, 3'd2, 3'd4, 3'd1,
              3'd2, 3'd4, 3'd3, 3'd0};
    return cm(1'($urandom_range(0, 1)),
              sizes[$urandom_range(0, 7)],
              25'($urandom), $urandom);
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t tv [11];
    cmd_t c0, c1;
    vec_t v;
    int   n;
    bit   seen;

    for (int d = 0; d < 2; d++) begin
      last[d] = 1'b1;
      lat[d]  = 0;
      for (int p = 0; p < 2; p++) begin
        req[d][p] = 1'b0;
        mrd[d][p] = '0;
        set_cmd(d, p, cm(0, 3'd1, '0, '0));
      end
    end
    img[25'h10] = 32'hDEADBEEF;

    tv[0]  = vt(0, 3, cm(0, 4, 25'h20, 0),
                cm(0, 4, 25'h24, 0), 5, 0, 0, 0);
    tv[1]  = vt(0, 3, cm(1, 4, 25'h28, 32'h11223344),
                cm(0, 1, 25'h2C, 0), 0, 0, 0, 0);
    tv[2]  = vt(0, 1, cm(0, 2, 25'h30, 0),
                cm(0, 4, 25'h0, 0), 3, 0, 0, 0);
    tv[3]  = vt(0, 3, cm(0, 4, 25'h34, 0),
                cm(0, 4, 25'h38, 0), 2, 1, 0, 0);
    tv[4]  = vt(1, 3, cm(0, 4, 25'h80, 0),
                cm(0, 4, 25'h84, 0), 3, 0, 0, 0);
    tv[5]  = vt(1, 1, cm(0, 4, 25'h88, 0),
                cm(0, 4, 25'h0, 0), 1, 0, 0, 0);
    tv[6]  = vt(1, 3, cm(0, 4, 25'h8C, 0),
                cm(1, 4, 25'h90, 32'h5), 2, 0, 0, 0);
    tv[7]  = vt(1, 1, cm(0, 4, 25'h94, 0),
                cm(0, 4, 25'h0, 0), 14, 0, 0, 0);
    tv[8]  = vt(1, 1, cm(0, 4, 25'h98, 0),
                cm(0, 4, 25'h0, 0), 15, 0, 1, 0);
    tv[9]  = vt(0, 2, cm(0, 4, 25'h0, 0),
                cm(0, 0, 25'h9C, 0), 4, 1, 0, 1);
    tv[10] = vt(0, 3, cm(0, 7, 25'hA4, 0),
                cm(0, 4, 25'hA0, 0), 4, 1, 1, 0);

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_start d%0d", d),
            32'(start[d]), 0);
      check($sformatf("rst_busy d%0d", d),
            32'(busy[d]), 0);
      check($sformatf("rst_grant d%0d", d),
            32'(gnt[d]), 0);
      check($sformatf("rst_done d%0d", d),
            {30'd0, done[d][0], done[d][1]}, 0);
      check($sformatf("rst_rdata d%0d", d),
            rd[d][0] | rd[d][1], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_round(tv[i]);

    // single load, first-edge latency, slow memory
    lat[0] = 70;
    c0 = cm(0, 4, 25'h10, 0);
    set_cmd(0, 0, c0);
    req[0][0] = 1'b1;
    @(negedge clk);
    check("h1_start", 32'(start[0]), 1);
    check("h1_busy", 32'(busy[0]), 1);
    check("h1_grant", 32'(gnt[0]), 0);
    check("h1_addr", 32'(maddr[0]), 32'h10);
    check("h1_nb", 32'(mnb[0]), 4);
    check("h1_wr", 32'(mwr[0]), 0);
    complete(0, 0, c0, 1'b0);
    check("h1_rdata", rd[0][0], 32'hDEADBEEF);
    tail(0);

    // p1 store with p0 arriving mid-transfer
    lat[0] = 12;
    c1 = cm(1, 2, 25'h1000004, 32'h0000A5A5);
    c0 = cm(0, 4, 25'h40, 0);
    set_cmd(0, 1, c1);
    req[0][1] = 1'b1;
    repeat (3) @(negedge clk);
    check("h2_wr", 32'(mwr[0]), 1);
    check("h2_nb", 32'(mnb[0]), 2);
    check("h2_addr", 32'(maddr[0]), 32'h1000004);
    check("h2_wdata", mwd[0], 32'h0000A5A5);
    set_cmd(0, 0, c0);
    req[0][0] = 1'b1;
    complete(0, 1, c1, 1'b0);
    complete(0, 0, c0, 1'b0);
    tail(0);

    // timeout with a silent controller
    lat[1] = 100;
    c0 = cm(0, 4, 25'h50, 0);
    set_cmd(1, 0, c0);
    req[1][0] = 1'b1;
    @(negedge clk);
    check("h3_start", 32'(start[1]), 1);
    n = 0;
    while (!done[1][0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("h3_cycles", n, 16);
    check("h3_err", 32'(err[1][0]), 1);
    check("h3_start_drop", 32'(start[1]), 0);
    check("h3_rdata", rd[1][0], mrd[1][0]);
    req[1][0] = 1'b0;
    last[1] = 1'b0;
    tail(1);

    // illegal size never reaches memory
    set_cmd(0, 0, cm(0, 3, 25'h70, 0));
    req[0][0] = 1'b1;
    @(negedge clk);
    check("h4_done", 32'(done[0][0]), 1);
    check("h4_err", 32'(err[0][0]), 1);
    check("h4_start", 32'(start[0]), 0);
    req[0][0] = 1'b0;
    tail(0);

    // reset during ISSUE
    lat[0] = 50;
    set_cmd(0, 0, cm(0, 4, 25'h60, 0));
    req[0][0] = 1'b1;
    repeat (5) @(negedge clk);
    check("h5_start", 32'(start[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("h5_async_start", 32'(start[0]), 0);
    check("h5_async_busy", 32'(busy[0]), 0);
    req[0][0] = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | done[0][0] | done[0][1];
    end
    check("h5_no_done", 32'(seen), 0);
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      last[d] = 1'b1;
      for (int p = 0; p < 2; p++) mrd[d][p] = '0;
    end
    check("h5_rdata_rst", rd[0][0], 0);
    run_round(vt(0, 3, cm(0, 4, 25'h64, 0),
                 cm(0, 4, 25'h68, 0), 4, 0, 0, 0));

    // random rounds against the reference model
    for (int r = 0; r < 40; r++) begin
      v.d  = int'($urandom_range(0, 1));
      v.m  = int'($urandom_range(1, 3));
      v.c0 = rnd_cmd();
      v.c1 = rnd_cmd();
      if (v.d == 1 && $urandom_range(0, 1) == 1)
        v.lat = int'($urandom_range(20, 30));
      else
        v.lat = int'($urandom_range(0, 10));
      if (v.m == 1) v.first = 0;
      else if (v.m == 2) v.first = 1;
      else if (v.d == 0) v.first = last[0] ? 0 : 1;
      else v.first = 0;
      v.e0 = !legal(v.c0.nb) ||
             (v.d == 1 && v.lat > 14);
      v.e1 = !legal(v.c1.nb) ||
             (v.d == 1 && v.lat > 14);
      run_round(v);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single mem_external SPI flash/RAM controller.
- Port 0 is the CPU instruction-fetch/load-store path. Port 1 is a secondary requester (debug loader / DMA).
- Grants one requester at a time and latches its command so the controller sees stable inputs.
- Drives the controller's level start/done handshake, returns read data and completion/error to the owning port, and enforces an optional timeout.

Parameters:
ROUND_ROBIN, 1, 1 = alternate grant on simultaneous requests; 0 = fixed priority, port 0 wins
TIMEOUT_CYCLES, 4096, max cycles in ISSUE waiting for mem_request_done; 0 disables timeout
TIMER_W, 13, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock
rst_n  in  1  reset
p0_req / p1_req  in  1  request valid; held until matching pX_done
p0_write / p1_write  in  1  1 = store, 0 = load
p0_num_bytes / p1_num_bytes  in  3  bytes to transfer, legal 1, 2, 4
p0_addr / p1_addr  in  25  target address; bit 24 is the flash/RAM select
p0_wdata / p1_wdata  in  32  store data
p0_done / p1_done  out  1  one-cycle completion pulse
p0_err / p1_err  out  1  one-cycle pulse coincident with done; 1 = timeout or illegal size
p0_rdata / p1_rdata  out  32  last load data for that port; held until that port's next successful load
mem_start_request  out  1  level start to mem_external
mem_is_write / mem_num_bytes / mem_target_address / mem_write_value  out  1/3/25/32  latched command
mem_fetched_value  in  32  read data from mem_external
mem_request_done  in  1  level done from mem_external
grant  out  1  index of the port owning the memory; valid while busy
busy  out  1  high when state != IDLE

Behaviour:
- Clock: clk. Reset: rst_n, asynchronous active-low.
- Reset values: all outputs 0, state IDLE, last_grant = 1 (so port 0 is preferred first), timer 0.
- States use one-hot encoding: IDLE = 3'b001, ISSUE = 3'b010, RELEASE = 3'b100.
- IDLE:
  - Only one pX_req high: select that port.
  - Both high: select !last_grant when ROUND_ROBIN = 1; select port 0 when ROUND_ROBIN = 0.
  - On select: latch the command into the mem_* registers, set grant and mem_start_request <= 1, clear the timer, go to ISSUE.
  - Latency: req sampled high at edge N gives mem_start_request high after edge N.
- IDLE, illegal size (num_bytes not 1, 2 or 4):
  - No memory access; mem_start_request stays 0.
  - Pulse pX_done and pX_err on the next cycle, then go to RELEASE.
- ISSUE, mem_request_done = 1:
  - Load: capture mem_fetched_value into pX_rdata. Store: pX_rdata unchanged.
  - Pulse pX_done. Set mem_start_request <= 0 and last_grant <= grant. Go to RELEASE.
- ISSUE, timeout: TIMEOUT_CYCLES != 0 and the timer reaches TIMEOUT_CYCLES-1 with no done.
  - Pulse pX_done and pX_err; rdata unchanged.
  - Set mem_start_request <= 0 and last_grant <= grant. Go to RELEASE.
- RELEASE:
  - Stay until mem_request_done = 0, then go to IDLE. Minimum one cycle.
  - This guarantees the controller has retired before the next grant.
- Requester rule:
  - pX_req must be low by the first IDLE cycle after its done. A req still high there is a new request.
  - The arbiter never re-grants from a stale done.
- The mem_* command outputs change only on a grant in IDLE and are stable through ISSUE/RELEASE.
- The non-granted port's req is ignored until IDLE; it has no effect on the ongoing transfer.
- pX_done pulses are mutually exclusive and occur at most once per grant.
- Reset mid-operation:
  - mem_start_request drops asynchronously; no done is generated.
  - mem_external shares rst_n so that its SPI sequence aborts.
- Width rules: addresses are passed through unmodified, with no wrap or alignment checks. Byte extraction and sign extension stay in the requester.

Decomposition:
- Package mem_arb_pkg: state one-hot localparams, legal num_bytes constants (NB_1 = 1, NB_2 = 2, NB_4 = 4).
- Sub-module mem_arb_timeout holds the timer: clear, enable, expired. It is optional and is removed when TIMEOUT_CYCLES = 0.
- Arbitration select is inline combinational logic.

Test Plan:
- p0 load, addr 0x000010, 4 bytes; memory model returns 0xDEADBEEF after 70 cycles -> mem_start_request rises 1 cycle after req; p0_done pulses once; p0_rdata = 0xDEADBEEF; p0_err = 0; busy returns to 0.
- p0 and p1 requests in the same cycle, ROUND_ROBIN = 1 -> p0 granted first; after release p1 is granted; repeat with both high -> order p0, p1, p0, p1. With ROUND_ROBIN = 0 -> p0 is always granted while held.
- p1 store, 2 bytes, wdata 0x0000A5A5, addr 0x1000004 -> mem_is_write = 1, mem_num_bytes = 2, address 0x1000004 stable until done; p1_rdata unchanged; p0 request raised mid-transfer is not granted until RELEASE completes.
- Memory never asserts done, TIMEOUT_CYCLES = 16 -> p0_done and p0_err pulse 16 cycles after mem_start_request rises; mem_start_request drops the same cycle.
- p0_num_bytes = 3 -> no mem_start_request; p0_done and p0_err pulse the next cycle.
- rst_n low mid-ISSUE -> mem_start_request drops asynchronously; no done pulse; after release the first request is serviced normally, with port 0 preferred.
